spis: RTL



---
 rtl/lycan_globals.sv | 8 +
 rtl/spi_pkg.sv | 11 +
 rtl/spis_sync_edge.sv | 31 +++
 rtl/spis.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lycan_globals.sv
// Lycan-wide widths shared by every peripheral slot.
package lycan_globals;
    localparam int usb_packet_width         = 32;
    localparam int periph_address_width     = 3;
    localparam int inputs_per_peripheral    = 8;
    localparam int outputs_per_peripheral   = 8;
    localparam int tristates_per_peripheral = 8;
endpackage

// File: rtl/spi_pkg.sv
// Field layout, defaults and state encoding for the SPI slave peripheral.
package spi_pkg;
    localparam int COUNT_MSB = 27;
    localparam int COUNT_LSB = 26;
    localparam int DATA_MSB  = 23;

    localparam logic [7:0] DEFAULT_FILL_BYTE    = 8'hFF;
    localparam int         DEFAULT_READ_TIMEOUT = 500000;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spis_state_t;
endpackage

// File: rtl/spis_sync_edge.sv
// Two-flop synchronizer with registered edge detect; level is aligned with the edge pulses.
module spis_sync_edge #(
    parameter int             W         = 3,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    logic [W-1:0] s1;
    logic [W-1:0] s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= RESET_VAL;
            s2    <= RESET_VAL;
            level <= RESET_VAL;
            rise  <= '0;
            fall  <= '0;
        end else begin
            s1    <= din;
            s2    <= s1;
            level <= s2;
            rise  <= s2 & ~level;
            fall  <= ~s2 & level;
        end
    end
endmodule

// File: rtl/spis.sv
// SPI mode-0 slave: bytes from MOSI are packed into RX words, TX words are split onto MISO.
module spis
    import lycan_globals::*;
    import spi_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE    = DEFAULT_FILL_BYTE,
    parameter int         READ_TIMEOUT = DEFAULT_READ_TIMEOUT
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [inputs_per_peripheral-1:0]                 in,
    output logic [outputs_per_peripheral-1:0]                out,
    output logic [tristates_per_peripheral-1:0]              tristate,
    input  logic [usb_packet_width-periph_address_width-1:0] tx_data,
    input  logic                                             tx_empty,
    output logic                                             tx_rden,
    output logic [usb_packet_width-periph_address_width-1:0] rx_data,
    output logic                                             rx_wren,
    input  logic                                             rx_full,
    output logic                                             idle
);
    localparam int TW = $clog2(READ_TIMEOUT + 1);

    logic [2:0] lvl, rise, fall;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;

    spis_sync_edge #(.W(3), .RESET_VAL(3'b010)) u_sync (
        .clk(clk), .rst(rst), .din(in[2:0]), .level(lvl), .rise(rise), .fall(fall)
    );

    assign sclk_rise = rise[0];
    assign sclk_fall = fall[0];
    assign cs_rise   = rise[1];
    assign cs_fall   = fall[1];
    assign mosi      = lvl[2];

    logic unused;
    assign unused = ^{in[inputs_per_peripheral-1:3], lvl[1:0], rise[2], fall[2],
                      tx_data[usb_packet_width-periph_address_width-1:COUNT_MSB+1],
                      tx_data[COUNT_LSB-1:DATA_MSB+1]};

    spis_state_t state;
    logic [3:0]  bit_cnt;
    logic [7:0]  rx_shreg, tx_shreg;
    logic        miso_z;
    logic        commit, load_now;
    logic [7:0]  next_tx;

    // TX word register and byte splitter.
    logic        w_valid;
    logic [1:0]  w_count, w_idx;
    logic [23:0] w_bytes;

    assign commit   = (state == SHIFT) && sclk_fall && (bit_cnt == 4'd8);
    assign load_now = !cs_rise && ((state == LOAD) || commit);

    always_comb begin
        next_tx = FILL_BYTE;
        if (w_valid) begin
            case (w_idx)
                2'd0:    next_tx = w_bytes[7:0];
                2'd1:    next_tx = w_bytes[15:8];
                default: next_tx = w_bytes[23:16];
            endcase
        end
    end

    // tx_rden is held off for the cycle it is high so the same head is never captured twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_rden <= 1'b0;
            w_valid <= 1'b0;
            w_count <= '0;
            w_idx   <= '0;
            w_bytes <= '0;
        end else begin
            tx_rden <= 1'b0;
            if (w_valid) begin
                if (load_now) begin
                    w_idx <= w_idx + 2'd1;
                    if (w_idx + 2'd1 == w_count) w_valid <= 1'b0;
                end
            end else if (!tx_empty && !tx_rden) begin
                tx_rden <= 1'b1;
                w_count <= tx_data[COUNT_MSB:COUNT_LSB];
                w_bytes <= tx_data[DATA_MSB:0];
                w_idx   <= '0;
                w_valid <= (tx_data[COUNT_MSB:COUNT_LSB] != 2'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shreg <= '0;
            tx_shreg <= '0;
            miso_z   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    miso_z  <= 1'b1;
                    bit_cnt <= '0;
                    if (cs_fall) state <= LOAD;
                end
                LOAD: begin
                    tx_shreg <= next_tx;
                    miso_z   <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise && bit_cnt != 4'd8) begin
                        rx_shreg <= {rx_shreg[6:0], mosi};
                        bit_cnt  <= bit_cnt + 4'd1;
                    end
                    if (sclk_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt  <= '0;
                            tx_shreg <= next_tx;
                        end else begin
                            tx_shreg <= {tx_shreg[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (cs_rise) begin
                state   <= IDLE;
                miso_z  <= 1'b1;
                bit_cnt <= '0;
            end
        end
    end

    assign out      = {{(outputs_per_peripheral-1){1'b0}}, tx_shreg[7]};
    assign tristate = {{(tristates_per_peripheral-1){1'b1}}, miso_z};

    // RX combiner with idle timeout.
    logic [1:0]    c_count, n_count;
    logic [23:0]   c_bytes, n_bytes;
    logic          pending, dec, tmo, flush;
    logic [TW-1:0] timer;

    always_comb begin
        n_bytes = c_bytes;
        n_count = c_count;
        if (commit && !pending) begin
            case (c_count)
                2'd0:    n_bytes[7:0]   = rx_shreg;
                2'd1:    n_bytes[15:8]  = rx_shreg;
                default: n_bytes[23:16] = rx_shreg;
            endcase
            n_count = c_count + 2'd1;
        end
        dec   = !pending && !commit && (c_count == 2'd1 || c_count == 2'd2);
        tmo   = dec && (timer == TW'(1));
        flush = !pending && ((n_count == 2'd3) || (cs_rise && n_count != 2'd0) || tmo);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_count <= '0;
            c_bytes <= '0;
            pending <= 1'b0;
            timer   <= TW'(READ_TIMEOUT);
            rx_wren <= 1'b0;
            rx_data <= '0;
        end else begin
            rx_wren <= 1'b0;
            if (pending) begin
                if (!rx_full) begin
                    rx_wren <= 1'b1;
                    rx_data <= {1'b0, c_count, 2'b00, c_bytes};
                    c_count <= '0;
                    c_bytes <= '0;
                    pending <= 1'b0;
                    timer   <= TW'(READ_TIMEOUT);
                end
            end else if (flush) begin
                timer <= TW'(READ_TIMEOUT);
                if (!rx_full) begin
                    rx_wren <= 1'b1;
                    rx_data <= {1'b0, n_count, 2'b00, n_bytes};
                    c_count <= '0;
                    c_bytes <= '0;
                end else begin
                    c_count <= n_count;
                    c_bytes <= n_bytes;
                    pending <= 1'b1;
                end
            end else begin
                c_count <= n_count;
                c_bytes <= n_bytes;
                if (commit)   timer <= TW'(READ_TIMEOUT);
                else if (dec) timer <= timer - TW'(1);
            end
        end
    end

    assign idle = (state == IDLE) && !pending && (c_count == 2'd0);
endmodule
